// File: rtl/dpram_reader_pkg.sv
// Shared types and helpers for the dual-port RAM stream reader.
// The optional end-of-transfer marker is enabled with DPRAM_READER_LAST_EN.
package dpram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // ceil(log2(depth)); depth is a power of two here, so this is exact
    function automatic int fifo_log2(input int depth);
        int r;
        r = 0;
        while ((1 << r) < depth) r++;
        return r;
    endfunction

endpackage

// File: rtl/dpram_reader_fifo.sv
// Small synchronous FIFO with flush and occupancy count for the stream reader.
// Read data is presented combinationally from the head entry (show-ahead).
module dpram_reader_fifo
    import dpram_reader_pkg::*;
#(
    parameter  int W     = 72,
    parameter  int DEPTH = 4,
    localparam int AW    = fifo_log2(DEPTH)
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic [AW:0]  count,
    output logic         empty
);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_rd;

    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage is cleared on reset so the stream data output reads zero.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/dpram_stream_reader.sv
// Streaming read engine: fetches `length` words from a RAM port into a valid/ready stream.
// Define DPRAM_READER_LAST_EN to add the m_last end-of-transfer marker.
module dpram_stream_reader
    import dpram_reader_pkg::*;
#(
    parameter int DATA       = 72,
    parameter int ADDR       = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            start,
    input  logic [ADDR-1:0] start_addr,
    input  logic [ADDR:0]   length,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [ADDR-1:0] ram_addr,
    output logic            ram_wr,
    input  logic [DATA-1:0] ram_dout,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DATA-1:0] m_data
`ifdef DPRAM_READER_LAST_EN
   ,output logic            m_last
`endif
);
    localparam int CW = fifo_log2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 1;
    localparam int LW = ADDR + 1;
`ifdef DPRAM_READER_LAST_EN
    localparam int FW = DATA + 1;
`else
    localparam int FW = DATA;
`endif

    state_t        state;
    logic [LW-1:0] remaining;
    logic          inflight;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic [FW-1:0] fifo_wdata;
    logic [FW-1:0] fifo_rdata;
    logic          issue;
    logic          pop;
    logic          drain_done;

    assign ram_wr  = 1'b0;
    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;
    assign m_data  = fifo_rdata[DATA-1:0];

    // Credit: words buffered plus the one possibly in flight must fit.
    assign issue = (state == FETCH) &&
                   ((SW'(fifo_count) + SW'(inflight)) < SW'(FIFO_DEPTH));

    // Finish on the edge that pops the last word so done lands the cycle after.
    assign drain_done = (state == DRAIN) && !inflight &&
                        (fifo_empty || (fifo_count == CW'(1) && pop));

`ifdef DPRAM_READER_LAST_EN
    logic inflight_last;
    assign fifo_wdata = {inflight_last, ram_dout};
    assign m_last     = m_valid && fifo_rdata[DATA];
`else
    assign fifo_wdata = ram_dout;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            inflight  <= 1'b0;
            ram_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DPRAM_READER_LAST_EN
            inflight_last <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            inflight <= issue && !abort;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        if (length != '0) begin
                            ram_addr  <= start_addr;
                            remaining <= length;
                            state     <= FETCH;
                            busy      <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                    FETCH: if (issue) begin
                        ram_addr  <= ram_addr + ADDR'(1);
                        remaining <= remaining - LW'(1);
`ifdef DPRAM_READER_LAST_EN
                        inflight_last <= (remaining == LW'(1));
`endif
                        if (remaining == LW'(1)) state <= DRAIN;
                    end
                    DRAIN: if (drain_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    dpram_reader_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .flush   (abort),
        .wr_en   (inflight),
        .wr_data (fifo_wdata),
        .rd_en   (pop),
        .rd_data (fifo_rdata),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Self-checking bench for dpram_stream_reader with a registered-read RAM model.
// Expected words come from the bench RAM image indexed by (start + k) mod 1024.
module tb_dpram_stream_reader;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        start;
    logic [9:0]  start_addr;
    logic [10:0] length;
    logic        abort;
    logic        busy;
    logic        done;
    logic [9:0]  ram_addr;
    logic        ram_wr;
    logic [71:0] ram_dout;
    logic        m_valid;
    logic        m_ready;
    logic [71:0] m_data;
`ifdef DPRAM_READER_LAST_EN
    logic        m_last;
`endif

    logic [71:0] ram [1024];
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) ram_dout <= ram[ram_addr];

    dpram_stream_reader dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .ram_addr   (ram_addr),
        .ram_wr     (ram_wr),
        .ram_dout   (ram_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef DPRAM_READER_LAST_EN
       ,.m_last     (m_last)
`endif
    );

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Runs one transfer and checks every word, timing and handshake rule.
    task automatic do_xfer(input logic [9:0] sa, input int len, input int rdy_pct, input bit poke);
        int k = 0, c = 0, first_c = -1, done_c = -1, idx;
        logic held = 1'b0;
        logic [71:0] held_data = '0;
        start = 1'b1; start_addr = sa; length = 11'(len); m_ready = 1'b0;
        step();
        start = 1'b0;
        total_cnt++;
        if (busy !== (len != 0)) $display("FAIL busy_after_start: got %b want %b", busy, len != 0);
        else pass_cnt++;
        if (len != 0) begin
            total_cnt++;
            if (ram_addr !== sa) $display("FAIL first_addr: got %h want %h", ram_addr, sa);
            else pass_cnt++;
        end
        while (c < 3000) begin
            start = poke && (c == 3);
            start_addr = sa + 10'd100;
            length = 11'd7;
            m_ready = ($urandom_range(99) < rdy_pct);
            if (held) begin
                total_cnt++;
                if (m_valid !== 1'b1 || m_data !== held_data)
                    $display("FAIL stall_stable: valid %b data %h want valid 1 data %h", m_valid, m_data, held_data);
                else pass_cnt++;
            end
            if (m_valid === 1'b1 && first_c < 0) first_c = c;
            if (m_valid === 1'b1 && m_ready) begin
                idx = (int'(sa) + k) % 1024;
                total_cnt++;
                if (k >= len || m_data !== ram[idx])
                    $display("FAIL word_%0d: got %h want %h", k, m_data, (k < len) ? ram[idx] : 72'hx);
                else pass_cnt++;
`ifdef DPRAM_READER_LAST_EN
                total_cnt++;
                if (m_last !== (k == len - 1)) $display("FAIL m_last_%0d: got %b want %b", k, m_last, k == len - 1);
                else pass_cnt++;
`endif
                k++;
            end
            if (done === 1'b1) begin
                done_c = c;
                break;
            end
            total_cnt++;
            if (busy !== 1'b1) $display("FAIL busy_during: got %b want 1 at cycle %0d", busy, c);
            else pass_cnt++;
            held = m_valid && !m_ready;
            held_data = m_data;
            step();
            c++;
        end
        start = 1'b0;
        m_ready = 1'b0;
        total_cnt++;
        if (done_c < 0) $display("FAIL done_timeout: got no done want done within 3000 cycles");
        else pass_cnt++;
        total_cnt++;
        if (k !== len) $display("FAIL word_count: got %0d want %0d", k, len);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL busy_at_done: got %b want 0", busy);
        else pass_cnt++;
        if (rdy_pct >= 100 && len > 0) begin
            total_cnt++;
            if (first_c !== 2) $display("FAIL first_latency: got %0d want 2", first_c);
            else pass_cnt++;
            total_cnt++;
            if (done_c !== len + 2) $display("FAIL done_cycle: got %0d want %0d", done_c, len + 2);
            else pass_cnt++;
        end
        if (len == 0) begin
            total_cnt++;
            if (done_c !== 0) $display("FAIL zero_len_done: got %0d want 0", done_c);
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if (done !== 1'b0 || m_valid !== 1'b0)
            $display("FAIL after_done: done %b valid %b want 0 0", done, m_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; abort = 1'b0; m_ready = 1'b0;
        repeat (2) step();
        total_cnt++;
        if ({busy, done, m_valid, ram_wr} !== 4'b0 || m_data !== '0 || ram_addr !== '0)
            $display("FAIL reset_values: busy %b done %b valid %b wr %b data %h addr %h want all 0",
                     busy, done, m_valid, ram_wr, m_data, ram_addr);
        else pass_cnt++;
`ifdef DPRAM_READER_LAST_EN
        total_cnt++;
        if (m_last !== 1'b0) $display("FAIL reset_m_last: got %b want 0", m_last);
        else pass_cnt++;
`endif
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        do_xfer(10'h010, 5, 100, 1'b0);
        do_xfer(10'h3FE, 4, 100, 1'b0);
        do_xfer(10'h055, 1, 100, 1'b0);
    endtask

    task automatic test_zero_len();
        do_xfer(10'h123, 0, 100, 1'b0);
        repeat (3) begin
            total_cnt++;
            if (m_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
                $display("FAIL zero_len_idle: valid %b done %b busy %b want 0 0 0", m_valid, done, busy);
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_backpressure();
        do_xfer(10'h200, 8, 50, 1'b1);
        do_xfer(10'h3FA, 8, 30, 1'b0);
    endtask

    task automatic test_abort();
        logic [9:0] sa;
        sa = 10'h3FC;
        start = 1'b1; start_addr = sa; length = 11'd16; m_ready = 1'b0;
        step();
        start = 1'b0;
        repeat (8) step();
        total_cnt++;
        if (ram_addr !== sa + 10'd4 || m_valid !== 1'b1 || m_data !== ram[sa] || busy !== 1'b1)
            $display("FAIL stall_credit: addr %h valid %b data %h busy %b want %h 1 %h 1",
                     ram_addr, m_valid, m_data, busy, sa + 10'd4, ram[sa]);
        else pass_cnt++;
        abort = 1'b1; start = 1'b1; start_addr = 10'h001; length = 11'd3;
        step();
        abort = 1'b0; start = 1'b0;
        repeat (5) begin
            total_cnt++;
            if (m_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
                $display("FAIL abort_idle: valid %b done %b busy %b want 0 0 0", m_valid, done, busy);
            else pass_cnt++;
            step();
        end
        start = 1'b1; start_addr = 10'h080; length = 11'd16; m_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        total_cnt++;
        if (m_valid !== 1'b0 || busy !== 1'b0) $display("FAIL abort_inflight: valid %b busy %b want 0 0", m_valid, busy);
        else pass_cnt++;
        repeat (4) begin
            total_cnt++;
            if (done !== 1'b0 || m_valid !== 1'b0) $display("FAIL abort_no_done: done %b valid %b want 0 0", done, m_valid);
            else pass_cnt++;
            step();
        end
        do_xfer(10'h0F0, 6, 70, 1'b0);
    endtask

    task automatic test_reset_mid();
        start = 1'b1; start_addr = 10'h2A0; length = 11'd16; m_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done, m_valid, ram_wr} !== 4'b0 || m_data !== '0 || ram_addr !== '0)
            $display("FAIL reset_mid: busy %b done %b valid %b wr %b data %h addr %h want all 0",
                     busy, done, m_valid, ram_wr, m_data, ram_addr);
        else pass_cnt++;
`ifdef DPRAM_READER_LAST_EN
        total_cnt++;
        if (m_last !== 1'b0) $display("FAIL reset_mid_m_last: got %b want 0", m_last);
        else pass_cnt++;
`endif
        m_ready = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        do_xfer(10'h2A0, 3, 100, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 5; t++)
            do_xfer(10'($urandom), $urandom_range(40, 1), $urandom_range(100, 20), 1'b0);
        do_xfer(10'($urandom), 1024, 100, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = {32'($urandom), 30'($urandom), 10'(i)};
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_random();
        total_cnt++;
        if (ram_wr !== 1'b0) $display("FAIL ram_wr: got %b want 0", ram_wr);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
